// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [31:0] HALT_WORD_DEFAULT = {OP_HALT, 26'd0};
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'd0;

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register: flush beats load, load beats drain,
// and the payload holds while valid is high and ready is low.
module fetch_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload flops are reset as well, so instr/pc read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= 32'd0;
      pc    <= 32'd0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, fetch FSM and output slot for the combinational instruction ROM.
// Optional out-of-range PC trap is enabled with `define FETCH_BOUND_CHECK_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t state;
  logic   redirect_take;
  logic   flush;
  logic   load_opp;
  logic   out_of_range;
  logic   load_slot;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    redirect_take = 1'b0;
    flush         = 1'b0;
    load_opp      = 1'b0;
    out_of_range  = 1'b0;
    load_slot     = 1'b0;

    redirect_take = redirect_valid && (state != ST_IDLE);
    flush         = redirect_take || start;
    load_opp      = (state == ST_FETCH) && (!instr_valid || instr_ready) && !flush;
`ifdef FETCH_BOUND_CHECK_EN
    out_of_range  = (pc >= 32'(DEPTH));
`endif
    load_slot     = load_opp && !out_of_range;
  end

  // Redirect outranks start, which outranks a normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else if (redirect_take) begin
      state <= ST_FETCH;
      pc    <= redirect_target;
    end else if (start) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
    end else if (load_slot) begin
      pc <= pc + 32'd1;
      if (rom_instr == HALT_WORD) state <= ST_HALT;
    end else if (load_opp && out_of_range) begin
      state <= ST_FAULT;
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (load_slot),
    .load_instr (rom_instr),
    .load_pc    (pc),
    .ready      (instr_ready),
    .instr      (instr_out),
    .pc         (instr_pc),
    .valid      (instr_valid)
  );

  assign halted = (state == ST_HALT) && !instr_valid;

`ifdef FETCH_BOUND_CHECK_EN
  assign rom_addr = pc;
  assign fault    = (state == ST_FAULT);
`else
  // Without the bound check the ROM simply sees the PC modulo its depth.
  assign rom_addr = {{(32 - AW){1'b0}}, pc[AW-1:0]};
  assign fault    = 1'b0;
`endif

endmodule
